// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader: FSM states and frame constants.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int         LEN_BYTES = 4;
    localparam logic [3:0] LANES_ALL = 4'b1111;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [29:0] mem_address;
    logic        mem_wen;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_byte_select;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_address, mem_wen, mem_data_in, mem_byte_select
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_address, mem_wen, mem_data_in, mem_byte_select
    );
endinterface

// File: rtl/prog_loader_assembler.sv
// Packs little-endian bytes into 32-bit words and keeps the running 8-bit data sum.
module prog_loader_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [31:0] word_nxt,
    output logic [7:0]  sum,
    output logic        word_full
);
    logic [31:0] word;
    logic [1:0]  idx;

    // word_nxt already holds the incoming byte so the 4th byte can be written without a bubble
    always_comb begin
        word_nxt = word;
        word_nxt[idx*8 +: 8] = data;
    end

    assign word_full = (idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word <= '0;
            idx  <= '0;
            sum  <= '0;
        end else if (clear) begin
            word <= '0;
            idx  <= '0;
            sum  <= '0;
        end else if (load) begin
            word <= word_nxt;
            idx  <= idx + 2'd1;
            sum  <= sum + data;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a length/data/checksum frame, writes words to program memory, releases the CPU.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'd0,
    parameter int          MAX_WORDS = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    state_t      state;
    logic [31:0] len;
    logic [1:0]  len_idx;
    logic [31:0] word_cnt;

    logic        accept;
    logic        restart;
    logic [31:0] len_nxt;
    logic [31:0] word_nxt;
    logic [7:0]  sum;
    logic        word_full;

    assign accept  = bus.rx_valid && bus.rx_ready;
    assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign len_nxt = {bus.rx_data, len[31:8]};

    prog_loader_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (restart),
        .load      (accept && state == S_DATA),
        .data      (bus.rx_data),
        .word_nxt  (word_nxt),
        .sum       (sum),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            bus.rx_ready        <= 1'b0;
            bus.mem_wen         <= 1'b0;
            bus.mem_address     <= BASE_ADDR;
            bus.mem_data_in     <= '0;
            bus.mem_byte_select <= '0;
            cpu_hold            <= 1'b1;
            done                <= 1'b0;
            error               <= 1'b0;
            len                 <= '0;
            len_idx             <= '0;
            word_cnt            <= '0;
        end else begin
            bus.mem_wen         <= 1'b0;
            bus.mem_byte_select <= '0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (restart) begin
                        state        <= S_LEN;
                        bus.rx_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        len          <= '0;
                        len_idx      <= '0;
                        word_cnt     <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len     <= len_nxt;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'(LEN_BYTES - 1)) begin
                            // full 32-bit compare so huge lengths cannot alias into range
                            if (len_nxt > 32'(MAX_WORDS)) begin
                                state        <= S_ERR;
                                bus.rx_ready <= 1'b0;
                                error        <= 1'b1;
                            end else if (len_nxt == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (accept && word_full) begin
                        state               <= S_WRITE;
                        bus.rx_ready        <= 1'b0;
                        bus.mem_wen         <= 1'b1;
                        bus.mem_byte_select <= LANES_ALL;
                        bus.mem_address     <= BASE_ADDR + word_cnt[29:0];
                        bus.mem_data_in     <= word_nxt;
                    end
                end
                S_WRITE: begin
                    word_cnt     <= word_cnt + 32'd1;
                    bus.rx_ready <= 1'b1;
                    state        <= (word_cnt + 32'd1 == len) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == sum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed frames for prog_loader; memory writes are checked against a queue of expected writes.
module tb_prog_loader;
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, error;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    prog_loader_if bus();

    prog_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && bus.mem_wen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h", bus.mem_address, bus.mem_data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_address), 32'(e.addr));
                chk("wr_data", bus.mem_data_in, e.data);
                chk("wr_bsel", 32'(bus.mem_byte_select), 32'hF);
                chk("wr_rx_ready", 32'(bus.rx_ready), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (!bus.rx_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n == 64) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1 (byte %h)", b);
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    // stall inserts the 1-0-0-1 gap pattern on data bytes
    task automatic send_frame(input bq_t b, input bit stall);
        int g;
        for (int i = 0; i < b.size(); i++) begin
            g = (stall && i >= 4 && i < b.size() - 1 && ((i % 4) == 0 || (i % 4) == 3)) ? 1 : 0;
            send_byte(b[i], g);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_levels(input string tag, input logic d, input logic e, input logic h);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
        chk({tag, "_data"}, bus.mem_data_in, 32'd0);
        chk({tag, "_bsel"}, 32'(bus.mem_byte_select), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        bq_t two_word, one_word;
        int n;
        two_word = '{8'h02, 8'h00, 8'h00, 8'h00,
                     8'h78, 8'h56, 8'h34, 8'h12,
                     8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
        one_word = '{8'h01, 8'h00, 8'h00, 8'h00,
                     8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Two-word image, sum of data bytes = 0x44C -> 0x4C
        exp_q.push_back('{30'd0, 32'h12345678});
        exp_q.push_back('{30'd1, 32'hDEADBEEF});
        pulse_start();
        send_frame(two_word, 1'b0);
        check_levels("two_word", 1'b1, 1'b0, 1'b0);

        // Restart from DONE: hold reasserted and done dropped on the start edge
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        start = 1'b0;
        exp_q.push_back('{30'd0, 32'h04030201});
        send_frame(one_word, 1'b0);
        check_levels("one_word", 1'b1, 1'b0, 1'b0);

        // Zero length, good and bad checksum
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        check_levels("zero_ok", 1'b1, 1'b0, 1'b0);
        pulse_start();
        send_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0);
        check_levels("zero_bad", 1'b0, 1'b1, 1'b1);

        // Oversize length 4097 rejected right after the 4th length byte
        pulse_start();
        send_frame('{8'h01, 8'h10, 8'h00, 8'h00}, 1'b0);
        check_levels("oversize", 1'b0, 1'b1, 1'b1);
        chk("oversize_rx_ready", 32'(bus.rx_ready), 32'd0);

        // Two-word image with stalls on the data bytes
        exp_q.push_back('{30'd0, 32'h12345678});
        exp_q.push_back('{30'd1, 32'hDEADBEEF});
        pulse_start();
        send_frame(two_word, 1'b1);
        check_levels("stall", 1'b1, 1'b0, 1'b0);

        // Wrong checksum after valid data: words written, then error
        two_word[12] = 8'h1C;
        exp_q.push_back('{30'd0, 32'h12345678});
        exp_q.push_back('{30'd1, 32'hDEADBEEF});
        pulse_start();
        send_frame(two_word, 1'b0);
        check_levels("bad_csum", 1'b0, 1'b1, 1'b1);
        two_word[12] = 8'h4C;

        // Reset after the first word is written; reset values appear before the next edge
        exp_q.push_back('{30'd0, 32'h12345678});
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(two_word[i], 0);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midload_first_write", 32'(exp_q.size()), 32'd0);
        send_byte(two_word[8], 0);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_reset_vals("midload_reset");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{30'd0, 32'h04030201});
        pulse_start();
        send_frame(one_word, 1'b0);
        check_levels("after_reset", 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
